// File: rtl/counter_bus_master_pkg.sv
// Shared types and default timing constants for the counter bus master.
package counter_bus_master_pkg;

  localparam int unsigned ALE_W_DEF = 1;
  localparam int unsigned RD_W_DEF  = 2;
  localparam int unsigned NC_DEF    = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned DW        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LATCH,
    ST_HOLD,
    ST_TURN,
    ST_READ,
    ST_NEXT
  } state_e;

endpackage

// File: rtl/counter_bus_master_if.sv
// Sweep handshake plus multiplexed address/data bus towards counter_top.
interface counter_bus_master_if;
  import counter_bus_master_pkg::*;

  logic          start;
  logic          busy;
  logic          done;
  logic          ale;
  logic          rd;
  logic          wr;
  logic [DW-1:0] ad_o;
  logic          ad_oe;
  logic [DW-1:0] ad_i;

  modport master (
    input  start, ad_i,
    output busy, done, ale, rd, wr, ad_o, ad_oe
  );

  modport slave (
    output start, ad_i,
    input  busy, done, ale, rd, wr, ad_o, ad_oe
  );
endinterface

// File: rtl/counter_bus_master_delta.sv
// Per-channel previous-sample register and wrapping new-minus-old difference.
module counter_bus_master_delta
  import counter_bus_master_pkg::*;
#(
  parameter int unsigned NC = NC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic [SEL_W-1:0] sel,
  input  logic [DW-1:0]    data,
  output logic [DW*NC-1:0] delta
);

  logic [DW*NC-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= '0;
      delta <= '0;
    end else if (sample) begin
      for (int unsigned k = 0; k < NC; k++) begin
        if (sel == SEL_W'(k)) begin
          delta[DW*k +: DW] <= data - prev[DW*k +: DW];
          prev[DW*k +: DW]  <= data;
        end
      end
    end
  end

endmodule

// File: rtl/counter_bus_master.sv
// Sweeps NC counter channels over a multiplexed ALE/RD bus and stores each count.
// Optional per-channel delta output enabled by COUNTER_BUS_MASTER_DELTA_EN.
module counter_bus_master
  import counter_bus_master_pkg::*;
#(
  parameter int unsigned ALE_W = ALE_W_DEF,
  parameter int unsigned RD_W  = RD_W_DEF,
  parameter int unsigned NC    = NC_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  counter_bus_master_if.master        bus,
  output logic [DW*NC-1:0]            count,
  output logic [DW*NC-1:0]            delta
);

  localparam int unsigned CW = 3;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NC - 1);
  localparam logic [CW-1:0]    ALE_LAST = CW'(ALE_W - 1);
  localparam logic [CW-1:0]    RD_LAST  = CW'(RD_W - 1);

  state_e           state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             sample_c;
  logic             busy_nxt, done_nxt, ale_nxt, rd_nxt, ad_oe_nxt;
  logic [DW-1:0]    ad_o_nxt;

  // Next state; bus outputs are decoded from the next state so they leave a flop.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = '0;
    sample_c  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_ADDR;
          sel_nxt   = '0;
        end
      end
      ST_ADDR:  state_nxt = ST_LATCH;
      ST_LATCH: begin
        if (cnt == ALE_LAST) state_nxt = ST_HOLD;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      ST_HOLD:  state_nxt = ST_TURN;
      ST_TURN:  state_nxt = ST_READ;
      ST_READ: begin
        if (cnt == RD_LAST) begin
          state_nxt = ST_NEXT;
          sample_c  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_NEXT: begin
        if (sel == SEL_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          sel_nxt   = sel + 1'b1;
          state_nxt = ST_ADDR;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt  = (state_nxt != ST_IDLE);
    done_nxt  = (state_nxt == ST_NEXT) && (sel_nxt == SEL_LAST);
    ale_nxt   = (state_nxt == ST_LATCH);
    rd_nxt    = (state_nxt != ST_READ);
    ad_oe_nxt = (state_nxt == ST_ADDR) || (state_nxt == ST_LATCH) || (state_nxt == ST_HOLD);
    ad_o_nxt  = ad_oe_nxt ? DW'(sel_nxt) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel       <= '0;
      cnt       <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.ale   <= 1'b0;
      bus.rd    <= 1'b1;
      bus.ad_oe <= 1'b0;
      bus.ad_o  <= '0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      cnt       <= cnt_nxt;
      bus.busy  <= busy_nxt;
      bus.done  <= done_nxt;
      bus.ale   <= ale_nxt;
      bus.rd    <= rd_nxt;
      bus.ad_oe <= ad_oe_nxt;
      bus.ad_o  <= ad_o_nxt;
    end
  end

  assign bus.wr = 1'b1;

  // Capture read data into the selected channel on the last READ edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (sample_c) begin
      for (int unsigned k = 0; k < NC; k++) begin
        if (sel == SEL_W'(k)) count[DW*k +: DW] <= bus.ad_i;
      end
    end
  end

`ifdef COUNTER_BUS_MASTER_DELTA_EN
  counter_bus_master_delta #(
    .NC(NC)
  ) u_delta (
    .clk    (clk),
    .rst    (rst),
    .sample (sample_c),
    .sel    (sel),
    .data   (bus.ad_i),
    .delta  (delta)
  );
`else
  assign delta = '0;
`endif

endmodule
